// File: rtl/mem_stage.sv
// MEM pipeline stage and MEM/WB register of the 5-stage MIPS core.
// Word-addressed data RAM with WAIT_CYCLES extra cycles per load/store.
// Optional misaligned-access detection is enabled by defining MEM_MISALIGN_CHECK_EN.
module mem_stage #(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [31:0] Alu_Result_mem,
  input  logic [31:0] rb_mem,
  input  logic        m2reg_mem,
  input  logic        wmem_mem,
  input  logic        wreg_mem,
  input  logic [4:0]  wn_mem,
  output logic        stall_mem,
  output logic [31:0] Alu_Result_wb,
  output logic [31:0] mem_data_wb,
  output logic        m2reg_wb,
  output logic        wreg_wb,
  output logic [4:0]  wn_wb,
  output logic        misalign_wb
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  state_t            state_r;
  state_t            state_nxt_s;
  logic [CNT_W-1:0]  cnt_r;
  logic [CNT_W-1:0]  cnt_nxt_s;
  logic              stall_s;
  logic              complete_s;
  logic              request_s;
  logic              load_s;
  logic              store_s;
  logic              misalign_s;
  logic [ADDR_W-1:0] word_idx_s;
  logic [31:0]       rd_data_s;
  logic [31:0]       ram_r [DEPTH];

  // A load that also carries a store request wins; the store is dropped.
  assign request_s  = m2reg_mem | wmem_mem;
  assign load_s     = m2reg_mem;
  assign store_s    = wmem_mem & ~m2reg_mem;
  // Upper address bits are discarded, so addresses wrap modulo the RAM depth.
  assign word_idx_s = Alu_Result_mem[ADDR_W+1:2];
  assign rd_data_s  = ram_r[word_idx_s];
  assign stall_mem  = stall_s;

`ifdef MEM_MISALIGN_CHECK_EN
  assign misalign_s = request_s & (Alu_Result_mem[1:0] != 2'b00);
`else
  assign misalign_s = 1'b0;
`endif

  // Next-state, wait counter and stall/complete decode for the access FSM.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    stall_s     = 1'b0;
    complete_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (misalign_s) begin
          complete_s = 1'b1;
        end else if (request_s) begin
          if (WAIT_CYCLES == 0) begin
            complete_s = 1'b1;
          end else begin
            stall_s     = 1'b1;
            cnt_nxt_s   = CNT_LOAD;
            state_nxt_s = ST_WAIT;
          end
        end else begin
          complete_s = 1'b0;
        end
      end
      ST_WAIT: begin
        if (cnt_r == {CNT_W{1'b0}}) begin
          complete_s  = 1'b1;
          state_nxt_s = ST_IDLE;
        end else begin
          stall_s   = 1'b1;
          cnt_nxt_s = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = {CNT_W{1'b0}};
      end
    endcase
  end

  // FSM state and wait counter registers.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Data RAM write port; a store commits once, on its completion edge.
  always_ff @(posedge Clock) begin
    if (!Reset && complete_s && store_s && !misalign_s) begin
      ram_r[word_idx_s] <= rb_mem;
    end
  end

  // MEM/WB register: bubble while stalled, capture the stage result otherwise.
  always_ff @(posedge Clock) begin
    if (Reset || stall_s) begin
      Alu_Result_wb <= 32'd0;
      mem_data_wb   <= 32'd0;
      m2reg_wb      <= 1'b0;
      wreg_wb       <= 1'b0;
      wn_wb         <= 5'd0;
      misalign_wb   <= 1'b0;
    end else begin
      Alu_Result_wb <= Alu_Result_mem;
      mem_data_wb   <= (load_s && !misalign_s) ? rd_data_s : 32'd0;
      m2reg_wb      <= m2reg_mem;
      wreg_wb       <= wreg_mem & ~misalign_s;
      wn_wb         <= wn_mem;
      misalign_wb   <= misalign_s;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage (WAIT_CYCLES=2 and WAIT_CYCLES=0 instances).
module tb_mem_stage;

  logic        Clock;
  logic        Reset;

  logic [31:0] alu_a, rb_a;
  logic        m2reg_a, wmem_a, wreg_a;
  logic [4:0]  wn_a;
  logic        stall_a;
  logic [31:0] alu_wb_a, mem_data_wb_a;
  logic        m2reg_wb_a, wreg_wb_a, misalign_wb_a;
  logic [4:0]  wn_wb_a;

  logic [31:0] alu_b, rb_b;
  logic        m2reg_b, wmem_b, wreg_b;
  logic [4:0]  wn_b;
  logic        stall_b;
  logic [31:0] alu_wb_b, mem_data_wb_b;
  logic        m2reg_wb_b, wreg_wb_b, misalign_wb_b;
  logic [4:0]  wn_wb_b;

  int n_checks;
  int n_fail;

`ifdef MEM_MISALIGN_CHECK_EN
  localparam int MIS_WAITS = 0;
`else
  localparam int MIS_WAITS = 2;
`endif

  mem_stage #(.ADDR_W(8), .WAIT_CYCLES(2)) dut_a (
    .Clock(Clock), .Reset(Reset),
    .Alu_Result_mem(alu_a), .rb_mem(rb_a), .m2reg_mem(m2reg_a), .wmem_mem(wmem_a),
    .wreg_mem(wreg_a), .wn_mem(wn_a), .stall_mem(stall_a),
    .Alu_Result_wb(alu_wb_a), .mem_data_wb(mem_data_wb_a), .m2reg_wb(m2reg_wb_a),
    .wreg_wb(wreg_wb_a), .wn_wb(wn_wb_a), .misalign_wb(misalign_wb_a)
  );

  mem_stage #(.ADDR_W(8), .WAIT_CYCLES(0)) dut_b (
    .Clock(Clock), .Reset(Reset),
    .Alu_Result_mem(alu_b), .rb_mem(rb_b), .m2reg_mem(m2reg_b), .wmem_mem(wmem_b),
    .wreg_mem(wreg_b), .wn_mem(wn_b), .stall_mem(stall_b),
    .Alu_Result_wb(alu_wb_b), .mem_data_wb(mem_data_wb_b), .m2reg_wb(m2reg_wb_b),
    .wreg_wb(wreg_wb_b), .wn_wb(wn_wb_b), .misalign_wb(misalign_wb_b)
  );

  always #5 Clock = ~Clock;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic set_a(input logic [31:0] alu, input logic [31:0] rb, input logic m2reg,
                       input logic wmem, input logic wreg, input logic [4:0] wn);
    alu_a = alu; rb_a = rb; m2reg_a = m2reg; wmem_a = wmem; wreg_a = wreg; wn_a = wn;
  endtask

  // Present one request on dut_a, hold it through the stall, then go idle.
  task automatic do_req(input string tag, input logic [31:0] alu, input logic [31:0] rb,
                        input logic m2reg, input logic wmem, input logic wreg,
                        input logic [4:0] wn, input int waits);
    set_a(alu, rb, m2reg, wmem, wreg, wn);
    for (int i = 0; i < waits; i++) begin
      #1;
      check_val({tag, "_stall_hi"}, {31'd0, stall_a}, 32'd1);
      if (i > 0) check_val({tag, "_bubble"}, {31'd0, wreg_wb_a}, 32'd0);
      tick();
    end
    #1;
    check_val({tag, "_stall_lo"}, {31'd0, stall_a}, 32'd0);
    tick();
    set_a(32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    Clock    = 1'b0;
    Reset    = 1'b1;
    set_a(32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0);
    alu_b = 32'd0; rb_b = 32'd0; m2reg_b = 1'b0; wmem_b = 1'b0; wreg_b = 1'b0; wn_b = 5'd0;
    tick();
    tick();
    check_val("rst_alu_wb", alu_wb_a, 32'd0);
    check_val("rst_wreg_wb", {31'd0, wreg_wb_a}, 32'd0);
    check_val("rst_stall", {31'd0, stall_a}, 32'd0);
    Reset = 1'b0;

    // ALU pass-through, no memory request
    set_a(32'h0000_1234, 32'd0, 1'b0, 1'b0, 1'b1, 5'd3);
    #1;
    check_val("alu_stall", {31'd0, stall_a}, 32'd0);
    tick();
    set_a(32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0);
    check_val("alu_res_wb", alu_wb_a, 32'h0000_1234);
    check_val("alu_wn_wb", {27'd0, wn_wb_a}, 32'd3);
    check_val("alu_wreg_wb", {31'd0, wreg_wb_a}, 32'd1);
    check_val("alu_m2reg_wb", {31'd0, m2reg_wb_a}, 32'd0);
    check_val("alu_mdata_wb", mem_data_wb_a, 32'd0);

    // Store then load with two wait states
    do_req("st20", 32'h0000_0020, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0, 5'd0, 2);
    do_req("ld20", 32'h0000_0020, 32'd0, 1'b1, 1'b0, 1'b1, 5'd5, 2);
    check_val("ld20_data", mem_data_wb_a, 32'hDEAD_BEEF);
    check_val("ld20_wn", {27'd0, wn_wb_a}, 32'd5);
    check_val("ld20_wreg", {31'd0, wreg_wb_a}, 32'd1);
    check_val("ld20_m2reg", {31'd0, m2reg_wb_a}, 32'd1);

    // Reset in the middle of a store's wait phase aborts the write
    do_req("st10a", 32'h0000_0010, 32'h1111_1111, 1'b0, 1'b1, 1'b0, 5'd0, 2);
    set_a(32'h0000_0010, 32'h2222_2222, 1'b0, 1'b1, 1'b0, 5'd0);
    tick();
    Reset = 1'b1;
    set_a(32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0);
    tick();
    tick();
    #1;
    check_val("rstmid_stall", {31'd0, stall_a}, 32'd0);
    check_val("rstmid_alu_wb", alu_wb_a, 32'd0);
    check_val("rstmid_wn_wb", {27'd0, wn_wb_a}, 32'd0);
    Reset = 1'b0;
    do_req("ld10", 32'h0000_0010, 32'd0, 1'b1, 1'b0, 1'b1, 5'd7, 2);
    check_val("ld10_data", mem_data_wb_a, 32'h1111_1111);

    // Address wrap: 0x400 aliases word 0
    do_req("st400", 32'h0000_0400, 32'h0000_00A5, 1'b0, 1'b1, 1'b0, 5'd0, 2);
    do_req("ld000", 32'h0000_0000, 32'd0, 1'b1, 1'b0, 1'b1, 5'd1, 2);
    check_val("wrap_data", mem_data_wb_a, 32'h0000_00A5);

    // Load and store both set: treated as a load, no write
    do_req("st30", 32'h0000_0030, 32'h0000_0055, 1'b0, 1'b1, 1'b0, 5'd0, 2);
    do_req("both30", 32'h0000_0030, 32'h0000_0099, 1'b1, 1'b1, 1'b1, 5'd2, 2);
    check_val("both_data", mem_data_wb_a, 32'h0000_0055);
    do_req("ld30", 32'h0000_0030, 32'd0, 1'b1, 1'b0, 1'b1, 5'd2, 2);
    check_val("both_nowrite", mem_data_wb_a, 32'h0000_0055);

    // Misaligned load at 0x22
    do_req("ld22", 32'h0000_0022, 32'd0, 1'b1, 1'b0, 1'b1, 5'd4, MIS_WAITS);
`ifdef MEM_MISALIGN_CHECK_EN
    check_val("mis_flag", {31'd0, misalign_wb_a}, 32'd1);
    check_val("mis_wreg", {31'd0, wreg_wb_a}, 32'd0);
`else
    check_val("mis_flag", {31'd0, misalign_wb_a}, 32'd0);
    check_val("mis_data", mem_data_wb_a, 32'hDEAD_BEEF);
`endif

    // Zero wait states: store then load on consecutive cycles
    alu_b = 32'h0000_0004; rb_b = 32'd7; wmem_b = 1'b1; m2reg_b = 1'b0; wreg_b = 1'b0; wn_b = 5'd0;
    #1;
    check_val("w0_st_stall", {31'd0, stall_b}, 32'd0);
    tick();
    rb_b = 32'd0; wmem_b = 1'b0; m2reg_b = 1'b1; wreg_b = 1'b1; wn_b = 5'd9;
    #1;
    check_val("w0_ld_stall", {31'd0, stall_b}, 32'd0);
    tick();
    alu_b = 32'd0; m2reg_b = 1'b0; wreg_b = 1'b0; wn_b = 5'd0;
    check_val("w0_ld_data", mem_data_wb_b, 32'd7);
    check_val("w0_ld_wn", {27'd0, wn_wb_b}, 32'd9);
    check_val("w0_ld_wreg", {31'd0, wreg_wb_b}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
